// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
// Holds the arbiter state encoding, the one-hot grant constants and the parameter defaults.
package wb_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned DAT_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // The state register is the only source of the grant vector.
  function automatic logic [1:0] state_gnt(input arb_state_e s);
    logic [1:0] g;
    g = GNT_NONE;
    case (s)
      ST_OWN0: g = GNT_M0;
      ST_OWN1: g = GNT_M1;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Ack watchdog: counts stalled strobe cycles, fires once at TIMEOUT-1 and
// keeps a saturating 8-bit tally of forced timeouts.
module wb_arb_wdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       run,
  input  logic       clear,
  output logic       fire,
  output logic [7:0] TO_CNT
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  to_q,  to_d;

  // clear takes priority over fire so a late ack always wins the race.
  always_comb begin
    fire  = run && !clear && (cnt_q == LIMIT);
    cnt_d = '0;
    if (run && !clear && !fire) begin
      cnt_d = cnt_q + 16'd1;
    end
    to_d = to_q;
    if (fire && (to_q != 8'hFF)) begin
      to_d = to_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      to_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign TO_CNT = to_q;

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin on contention, owner keeps the bus
// while its CYC stays high, watchdog forces an error on a stalled strobe.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DAT_W   = DAT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              M0_CYC,
  input  logic              M0_STB,
  input  logic              M0_WE,
  input  logic [ADDR_W-1:0] M0_ADR,
  input  logic [DAT_W-1:0]  M0_DAT_I,
  output logic [DAT_W-1:0]  M0_DAT_O,
  output logic              M0_ACK,
  output logic              M0_ERR,
  input  logic              M1_CYC,
  input  logic              M1_STB,
  input  logic              M1_WE,
  input  logic [ADDR_W-1:0] M1_ADR,
  input  logic [DAT_W-1:0]  M1_DAT_I,
  output logic [DAT_W-1:0]  M1_DAT_O,
  output logic              M1_ACK,
  output logic              M1_ERR,
  output logic              S_CYC,
  output logic              S_STB,
  output logic              S_WE,
  output logic [ADDR_W-1:0] S_ADR,
  output logic [DAT_W-1:0]  S_DAT_O,
  input  logic [DAT_W-1:0]  S_DAT_I,
  input  logic              S_ACK,
  input  logic              S_ERR,
  output logic [1:0]        GNT,
  output logic [7:0]        TO_CNT
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // 1 = master 1 was granted most recently

  logic              own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0] own_adr;
  logic [DAT_W-1:0]  own_dat;
  logic [1:0]        gnt;
  logic              wd_run, wd_clear, forced_err;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (M0_CYC && M1_CYC) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
          last_d  = !last_q;
        end else if (M0_CYC) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (M1_CYC) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end
      end
      // Handover always drains through IDLE; never jump OWN0 <-> OWN1.
      ST_OWN0: if (!M0_CYC) state_d = ST_IDLE;
      ST_OWN1: if (!M1_CYC) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign gnt = state_gnt(state_q);
  assign GNT = gnt;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    case (state_q)
      ST_OWN0: begin
        own_cyc = M0_CYC;
        own_stb = M0_STB;
        own_we  = M0_WE;
        own_adr = M0_ADR;
        own_dat = M0_DAT_I;
      end
      ST_OWN1: begin
        own_cyc = M1_CYC;
        own_stb = M1_STB;
        own_we  = M1_WE;
        own_adr = M1_ADR;
        own_dat = M1_DAT_I;
      end
      default: ;
    endcase
  end

  // A strobe without CYC is an abort, so it must not keep the watchdog running.
  assign wd_run   = (state_q != ST_IDLE);
  assign wd_clear = !(own_cyc && own_stb) || S_ACK || S_ERR;

  wb_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .CLK    (CLK),
    .RST    (RST),
    .run    (wd_run),
    .clear  (wd_clear),
    .fire   (forced_err),
    .TO_CNT (TO_CNT)
  );

  assign S_CYC   = own_cyc;
  assign S_STB   = own_stb && !forced_err;
  assign S_WE    = own_we;
  assign S_ADR   = own_adr;
  assign S_DAT_O = own_dat;

  assign M0_ACK   = S_ACK && gnt[0];
  assign M0_ERR   = (S_ERR || forced_err) && gnt[0];
  assign M0_DAT_O = gnt[0] ? S_DAT_I : '0;
  assign M1_ACK   = S_ACK && gnt[1];
  assign M1_ERR   = (S_ERR || forced_err) && gnt[1];
  assign M1_DAT_O = gnt[1] ? S_DAT_I : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: cycle-by-cycle vector table plus hand-written
// watchdog, reset and saturation sequences (TIMEOUT overridden to 16).
module tb_wb_arbiter;

  logic        CLK, RST;
  logic        M0_CYC, M0_STB, M0_WE, M0_ACK, M0_ERR;
  logic [15:0] M0_ADR;
  logic [7:0]  M0_DAT_I, M0_DAT_O;
  logic        M1_CYC, M1_STB, M1_WE, M1_ACK, M1_ERR;
  logic [15:0] M1_ADR;
  logic [7:0]  M1_DAT_I, M1_DAT_O;
  logic        S_CYC, S_STB, S_WE, S_ACK, S_ERR;
  logic [15:0] S_ADR;
  logic [7:0]  S_DAT_O, S_DAT_I;
  logic [1:0]  GNT;
  logic [7:0]  TO_CNT;

  wb_arbiter #(.ADDR_W(16), .DAT_W(8), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .M0_CYC(M0_CYC), .M0_STB(M0_STB), .M0_WE(M0_WE), .M0_ADR(M0_ADR),
    .M0_DAT_I(M0_DAT_I), .M0_DAT_O(M0_DAT_O), .M0_ACK(M0_ACK), .M0_ERR(M0_ERR),
    .M1_CYC(M1_CYC), .M1_STB(M1_STB), .M1_WE(M1_WE), .M1_ADR(M1_ADR),
    .M1_DAT_I(M1_DAT_I), .M1_DAT_O(M1_DAT_O), .M1_ACK(M1_ACK), .M1_ERR(M1_ERR),
    .S_CYC(S_CYC), .S_STB(S_STB), .S_WE(S_WE), .S_ADR(S_ADR),
    .S_DAT_O(S_DAT_O), .S_DAT_I(S_DAT_I), .S_ACK(S_ACK), .S_ERR(S_ERR),
    .GNT(GNT), .TO_CNT(TO_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic [2:0]  m0;   // {cyc, stb, we}
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [2:0]  m1;
    logic [15:0] a1;
    logic [7:0]  d1;
    logic [7:0]  sd;
    logic        sack;
    logic        serr;
  } in_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [2:0]  sc;   // {S_CYC, S_STB, S_WE}
    logic [15:0] sa;
    logic [7:0]  sdo;
    logic [1:0]  ae0;  // {M0_ACK, M0_ERR}
    logic [7:0]  do0;
    logic [1:0]  ae1;
    logic [7:0]  do1;
    logic [7:0]  to;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  localparam out_t OZ = '0;

  out_t act;
  assign act = {GNT, S_CYC, S_STB, S_WE, S_ADR, S_DAT_O, M0_ACK, M0_ERR, M0_DAT_O,
                M1_ACK, M1_ERR, M1_DAT_O, TO_CNT};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  vec_t tbl[$];

  function automatic in_t mi(bit r, bit [2:0] m0, bit [15:0] a0, bit [7:0] d0,
                             bit [2:0] m1, bit [15:0] a1, bit [7:0] d1,
                             bit [7:0] sd, bit sack, bit serr);
    in_t v;
    v.rst = r; v.m0 = m0; v.a0 = a0; v.d0 = d0;
    v.m1 = m1; v.a1 = a1; v.d1 = d1;
    v.sd = sd; v.sack = sack; v.serr = serr;
    return v;
  endfunction

  function automatic out_t mo(bit [1:0] g, bit [2:0] sc, bit [15:0] sa, bit [7:0] sdo,
                              bit [1:0] ae0, bit [7:0] do0, bit [1:0] ae1, bit [7:0] do1,
                              bit [7:0] to);
    out_t v;
    v.gnt = g; v.sc = sc; v.sa = sa; v.sdo = sdo;
    v.ae0 = ae0; v.do0 = do0; v.ae1 = ae1; v.do1 = do1; v.to = to;
    return v;
  endfunction

  function automatic void add(in_t i, out_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic drive(input in_t v);
    RST = v.rst;
    {M0_CYC, M0_STB, M0_WE} = v.m0; M0_ADR = v.a0; M0_DAT_I = v.d0;
    {M1_CYC, M1_STB, M1_WE} = v.m1; M1_ADR = v.a1; M1_DAT_I = v.d1;
    S_DAT_I = v.sd; S_ACK = v.sack; S_ERR = v.serr;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    drive(mi(1'b1, 3'b000, 16'h0, 8'h0, 3'b000, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0));
    @(posedge CLK);
    @(posedge CLK);

    // single read by master 0, ack with 0xA5 on the fourth owned cycle
    add(mi(1'b1, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b110, 16'h0010, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b110, 16'h0010, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b110, 16'h0010, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b110, 16'h0010, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b110, 16'h0010, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b110, 16'h0010, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b1),
        mo(2'b01, 3'b110, 16'h0010, 8'h00, 2'b01, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b110, 16'h0010, 8'h00, 3'b000, 16'h0000, 8'h00, 8'hA5, 1'b1, 1'b0),
        mo(2'b01, 3'b110, 16'h0010, 8'h00, 2'b10, 8'hA5, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b000, 16'h0000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h5A, 1'b1, 1'b0), OZ);
    // contention from reset: 0, 1, 0, 1 with an IDLE cycle between owners
    add(mi(1'b1, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b100, 16'h1111, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b000, 16'h0000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h3C, 1'b1, 1'b0),
        mo(2'b10, 3'b100, 16'h2222, 8'h00, 2'b00, 8'h00, 2'b10, 8'h3C, 8'd0));
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b10, 3'b000, 16'h0000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b100, 16'h1111, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b000, 16'h0000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b100, 16'h1111, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b10, 3'b100, 16'h2222, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b10, 3'b000, 16'h0000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    // four back-to-back writes by master 0 while master 1 waits
    add(mi(1'b0, 3'b111, 16'h0020, 8'h01, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b111, 16'h0020, 8'h01, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b1, 1'b0),
        mo(2'b01, 3'b111, 16'h0020, 8'h01, 2'b10, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b111, 16'h0021, 8'h02, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b1, 1'b0),
        mo(2'b01, 3'b111, 16'h0021, 8'h02, 2'b10, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b111, 16'h0022, 8'h03, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b1, 1'b0),
        mo(2'b01, 3'b111, 16'h0022, 8'h03, 2'b10, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b111, 16'h0023, 8'h04, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b1, 1'b0),
        mo(2'b01, 3'b111, 16'h0023, 8'h04, 2'b10, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b01, 3'b000, 16'h0000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0), OZ);
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b100, 16'h2222, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b10, 3'b100, 16'h2222, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0),
        mo(2'b10, 3'b000, 16'h0000, 8'h00, 2'b00, 8'h00, 2'b00, 8'h00, 8'd0));
    add(mi(1'b0, 3'b000, 16'h0000, 8'h00, 3'b000, 16'h0000, 8'h00, 8'h00, 1'b0, 1'b0), OZ);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      drive(tbl[i].i);
      #1;
      chk($sformatf("vec%0d", i), 64'(act), 64'(tbl[i].e));
    end

    // master 1 stalls: forced error 15 owned cycles after strobe, STB masked
    @(negedge CLK);
    drive(mi(1'b0, 3'b000, 16'h0, 8'h0, 3'b110, 16'h0030, 8'h0, 8'h0, 1'b0, 1'b0));
    #1 chk("to_idle", 64'(GNT), 64'(2'b00));
    for (int k = 0; k <= 16; k++) begin
      @(negedge CLK);
      #1;
      if (k == 15)
        chk("to_fire", 64'({GNT, S_STB, M1_ERR, M0_ERR, TO_CNT}), 64'({2'b10, 1'b0, 1'b1, 1'b0, 8'd0}));
      else
        chk($sformatf("to_wait%0d", k), 64'({GNT, S_STB, M1_ERR, M0_ERR, TO_CNT}),
            64'({2'b10, 1'b1, 1'b0, 1'b0, (k == 16) ? 8'd1 : 8'd0}));
    end
    @(negedge CLK);
    drive(mi(1'b0, 3'b000, 16'h0, 8'h0, 3'b000, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0));
    @(negedge CLK);
    #1 chk("to_release", 64'({GNT, S_CYC}), 64'({2'b00, 1'b0}));

    // ack lands exactly when the counter sits at TIMEOUT-1: ack wins
    drive(mi(1'b0, 3'b110, 16'h0040, 8'h0, 3'b000, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0));
    for (int k = 0; k <= 15; k++) begin
      @(negedge CLK);
      if (k == 15) begin
        S_ACK = 1'b1;
        S_DAT_I = 8'h77;
      end
      #1;
      if (k == 15)
        chk("race_ack", 64'({GNT, S_STB, M0_ACK, M0_ERR, M0_DAT_O}), 64'({2'b01, 1'b1, 1'b1, 1'b0, 8'h77}));
      else
        chk($sformatf("race_wait%0d", k), 64'({GNT, S_STB, M0_ACK, M0_ERR}), 64'({2'b01, 1'b1, 1'b0, 1'b0}));
    end
    @(negedge CLK);
    drive(mi(1'b0, 3'b000, 16'h0, 8'h0, 3'b000, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0));
    #1 chk("race_tocnt", 64'(TO_CNT), 64'(8'd1));

    // reset while master 0 owns the bus with a strobe pending
    @(negedge CLK);
    drive(mi(1'b0, 3'b110, 16'h0050, 8'h0, 3'b000, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0));
    @(negedge CLK);
    #1 chk("rst_owned", 64'({GNT, S_CYC}), 64'({2'b01, 1'b1}));
    @(negedge CLK);
    RST = 1'b1;
    #1 chk("rst_sync", 64'(GNT), 64'(2'b01));
    @(negedge CLK);
    RST = 1'b0;
    S_ACK = 1'b1;
    S_DAT_I = 8'h99;
    #1 chk("rst_drop", 64'({GNT, S_CYC, TO_CNT, M0_ACK, M0_ERR, M0_DAT_O}),
           64'({2'b00, 1'b0, 8'd0, 1'b0, 1'b0, 8'h00}));
    @(negedge CLK);
    S_ACK = 1'b0;
    #1 chk("rst_regrant", 64'({GNT, S_CYC, S_ADR}), 64'({2'b01, 1'b1, 16'h0050}));

    // TO_CNT saturates: 256 timeouts of 16 cycles each
    @(negedge CLK);
    drive(mi(1'b0, 3'b000, 16'h0, 8'h0, 3'b000, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0));
    @(negedge CLK);
    drive(mi(1'b0, 3'b000, 16'h0, 8'h0, 3'b110, 16'h0060, 8'h0, 8'h0, 1'b0, 1'b0));
    @(posedge CLK);
    repeat (16 * 256) @(posedge CLK);
    @(negedge CLK);
    #1 chk("sat_tocnt", 64'({GNT, TO_CNT}), 64'({2'b10, 8'd255}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
